// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, funct3 access codes and the LOAD/STORE opcodes also used by the ALU.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Stores only have signed-size encodings; loads add the unsigned variants.
  function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables and replicated write data on the
// store side, lane selection and sign/zero extension on the load side. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enable the addressed lanes and replicate the datum across the word.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be    = 4'b1111;
    wdata = store_data;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = 8'(rdata >> {ld_addr_lo, 3'b000});
  assign ld_half = 16'(rdata >> {ld_addr_lo[1], 4'b0000});

  // Load side: pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid transaction per load/store instruction,
// stalling the core while the access is outstanding. A timeout of MAX_WAIT cycles
// in REQ/WAIT aborts with bus_err.
// Optional: define LSU_MISALIGN_CHK_EN to reject misaligned halves/words with misalign_err.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        load_flag,
  input  logic        store_flag,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_err
);

  lsu_state_t  state, state_n;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        is_store_q;
  logic        err_q;
  logic        mis_q;

  logic        access;
  logic        bad_req;
  logic        misal;
  logic        timeout;
  logic        abort;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_data_c;

  assign access  = load_flag | store_flag;
  assign bad_req = (load_flag & store_flag) | ~f3_supported(store_flag, funct3);
  assign timeout = (cnt + 16'd1) == 16'(MAX_WAIT);
  // A grant or response on the last allowed cycle still wins over the timeout.
  assign abort   = timeout & (((state == S_REQ) & ~mem_gnt) | ((state == S_WAIT) & ~mem_rvalid));

`ifdef LSU_MISALIGN_CHK_EN
  assign misal = f3_misaligned(funct3, addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  lsu_align u_align (
    .size       (funct3[1:0]),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_data_c)
  );

  // State register; async reset drops mem_req/stall immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (access) state_n = (bad_req | misal) ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_gnt)    state_n = is_store_q ? S_RESP : S_WAIT;
        else if (abort) state_n = S_RESP;
      end
      S_WAIT: if (mem_rvalid | abort) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the per-instruction flags.
  always_comb begin
    mem_req      = (state == S_REQ);
    mem_we       = (state == S_REQ) & is_store_q;
    stall        = ((state == S_IDLE) & access) | (state == S_REQ) | (state == S_WAIT);
    wb_valid     = (state == S_RESP) & ~is_store_q & ~err_q & ~mis_q;
    bus_err      = (state == S_RESP) & err_q;
    misalign_err = (state == S_RESP) & mis_q;
  end

  // Request latching, timeout counter and load-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_data    <= '0;
      cnt        <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (access) begin
          mem_addr   <= {addr[31:2], 2'b00};
          mem_be     <= be_c;
          mem_wdata  <= wdata_c;
          f3_q       <= funct3;
          lo_q       <= addr[1:0];
          is_store_q <= store_flag;
          err_q      <= bad_req;
          mis_q      <= misal & ~bad_req;
          cnt        <= '0;
        end
        S_REQ, S_WAIT: begin
          cnt <= cnt + 16'd1;
          if (abort) err_q <= 1'b1;
          if ((state == S_WAIT) && mem_rvalid) wb_data <= ld_data_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu. A second instance with MAX_WAIT=4 and
// its own flags/handshake exercises the timeout path.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        load_flag, store_flag;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, stall, wb_valid, bus_err, misalign_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;

  logic        load_flag4, store_flag4, gnt4, rvalid4;
  logic        mem_req4, mem_we4, stall4, wb_valid4, bus_err4, misalign_err4;
  logic [31:0] mem_addr4, mem_wdata4, wb_data4;
  logic [3:0]  mem_be4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lsu #(.MAX_WAIT(255)) dut (
    .clk(clk), .rst(rst), .addr(addr), .load_flag(load_flag), .store_flag(store_flag),
    .funct3(funct3), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  lsu #(.MAX_WAIT(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr), .load_flag(load_flag4), .store_flag(store_flag4),
    .funct3(funct3), .store_data(store_data), .mem_req(mem_req4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_be(mem_be4), .mem_wdata(mem_wdata4), .mem_gnt(gnt4),
    .mem_rvalid(rvalid4), .mem_rdata(mem_rdata), .stall(stall4), .wb_valid(wb_valid4),
    .wb_data(wb_data4), .bus_err(bus_err4), .misalign_err(misalign_err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store_op(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    addr = a; funct3 = f3; store_data = d; store_flag = 1'b1; mem_gnt = 1'b1;
    #1;
    check({tag, "_idle_stall"}, 32'(stall), 32'd1);
    check({tag, "_idle_noreq"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_req_stall"}, 32'(stall), 32'd1);
    tick();
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_nowb"}, 32'(wb_valid), 32'd0);
    check({tag, "_resp_noerr"}, 32'(bus_err), 32'd0);
    store_flag = 1'b0; mem_gnt = 1'b0;
    tick();
    check({tag, "_idle_after"}, {30'd0, stall, mem_req}, 32'd0);
  endtask

  task automatic load_op(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] rd, input int gap, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wb);
    addr = a; funct3 = f3; load_flag = 1'b1; mem_gnt = 1'b1;
    #1;
    check({tag, "_idle_stall"}, 32'(stall), 32'd1);
    tick();
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    tick();
    mem_gnt = 1'b0;
    check({tag, "_wait_noreq"}, 32'(mem_req), 32'd0);
    check({tag, "_wait_stall"}, 32'(stall), 32'd1);
    for (int i = 1; i < gap; i++) begin
      tick();
      check({tag, "_wait_hold"}, 32'(stall), 32'd1);
    end
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_data"}, wb_data, exp_wb);
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_errs"}, {30'd0, bus_err, misalign_err}, 32'd0);
    load_flag = 1'b0;
    tick();
    check({tag, "_wb_one_cycle"}, 32'(wb_valid), 32'd0);
  endtask

  task automatic err_op(input string tag, input logic ld, input logic st, input logic [2:0] f3);
    addr = 32'h0000_0300; funct3 = f3; load_flag = ld; store_flag = st;
    #1;
    check({tag, "_idle_stall"}, 32'(stall), 32'd1);
    check({tag, "_idle_noreq"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, "_bus_err"}, 32'(bus_err), 32'd1);
    check({tag, "_resp_noreq"}, 32'(mem_req), 32'd0);
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_nowb"}, 32'(wb_valid), 32'd0);
    load_flag = 1'b0; store_flag = 1'b0;
    tick();
    check({tag, "_err_one_cycle"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr = '0; load_flag = 1'b0; store_flag = 1'b0; funct3 = '0;
    store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    load_flag4 = 1'b0; store_flag4 = 1'b0; gnt4 = 1'b0; rvalid4 = 1'b0;
    #3;
    check("rst_ctrl", {26'd0, mem_req, mem_we, wb_valid, bus_err, misalign_err, stall}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_be_wdata", {28'd0, mem_be} | mem_wdata, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // SW word store, granted on the first REQ cycle.
    store_op("sw", 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    // SH to the upper half, low addr bit clear.
    store_op("sh", 32'h0000_0006, 3'b001, 32'h0000_ABCD, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD);
    // SB to byte 1.
    store_op("sb", 32'h0000_0101, 3'b000, 32'h1234_5655, 32'h0000_0100, 4'b0010, 32'h5555_5555);

    // LB / LBU of byte 3 with rvalid 3 cycles after gnt.
    load_op("lb", 32'h0000_0203, 3'b000, 32'h80FF_1234, 3, 32'h0000_0200, 4'b1000, 32'hFFFF_FF80);
    load_op("lbu", 32'h0000_0203, 3'b100, 32'h80FF_1234, 3, 32'h0000_0200, 4'b1000, 32'h0000_0080);
    // LHU of the upper half, next-cycle response.
    load_op("lhu", 32'h0000_0012, 3'b101, 32'h8001_7FFF, 1, 32'h0000_0010, 4'b1100, 32'h0000_8001);

    // Request-level errors: both flags, unsupported load and store funct3.
    err_op("both_flags", 1'b1, 1'b1, 3'b010);
    err_op("ld_f3_011", 1'b1, 1'b0, 3'b011);
    err_op("st_f3_100", 1'b0, 1'b1, 3'b100);

    // Timeout on the MAX_WAIT=4 instance: grant never comes.
    addr = 32'h0000_0040; funct3 = 3'b010; load_flag4 = 1'b1;
    #1;
    check("to_idle_stall", 32'(stall4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_req_held", {30'd0, mem_req4, bus_err4}, 32'd2);
    end
    tick();
    check("to_bus_err", 32'(bus_err4), 32'd1);
    check("to_req_drop", 32'(mem_req4), 32'd0);
    check("to_no_wb", 32'(wb_valid4), 32'd0);
    check("to_stall_rel", 32'(stall4), 32'd0);
    load_flag4 = 1'b0;
    tick();
    check("to_idle", {29'd0, bus_err4, mem_req4, stall4}, 32'd0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_CHK_EN
    addr = 32'h0000_0102; funct3 = 3'b010; load_flag = 1'b1;
    #1;
    tick();
    check("lw_mis_pulse", 32'(misalign_err), 32'd1);
    check("lw_mis_noreq", 32'(mem_req), 32'd0);
    check("lw_mis_nowb", {30'd0, wb_valid, bus_err}, 32'd0);
    load_flag = 1'b0;
    tick();
    check("lw_mis_one_cycle", 32'(misalign_err), 32'd0);
    // Leave a known non-zero wb_data for the reset check below.
    load_op("lw_prime", 32'h0000_0100, 3'b010, 32'h1234_5678, 1, 32'h0000_0100, 4'b1111, 32'h1234_5678);
`else
    load_op("lw_lowbits", 32'h0000_0102, 3'b010, 32'h1234_5678, 1, 32'h0000_0100, 4'b1111, 32'h1234_5678);
`endif

    // Reset asserted while a load sits in WAIT.
    addr = 32'h0000_0002; funct3 = 3'b001; load_flag = 1'b1; mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    check("rw_in_wait", 32'(stall), 32'd1);
    #2;
    rst = 1'b1; load_flag = 1'b0;
    #1;
    check("rw_req_low", 32'(mem_req), 32'd0);
    check("rw_stall_low", 32'(stall), 32'd0);
    check("rw_wb_data_clr", wb_data, 32'd0);
    tick();
    check("rw_no_resp", {30'd0, wb_valid, bus_err}, 32'd0);
    rst = 1'b0;
    tick();
    load_op("lh_after_rst", 32'h0000_0002, 3'b001, 32'h8001_0000, 1, 32'h0000_0000, 4'b1100, 32'hFFFF_8001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the single-issue RISC-V core.
- Consumes the ALU's effective address and load/store flags, plus rs2 data and funct3 from decode.
- Performs one req/gnt/rvalid transaction on the data-memory port and returns sign/zero-extended load data to writeback.
- Stalls the core (PC and register file hold) while the access is in flight.

Parameters:
- MAX_WAIT, 255: cycles allowed in REQ or WAIT before abort with bus_err. Range 1..65535; counter is 16 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- addr  in  32  effective address from ALU
- load_flag  in  1  ALU marks current instruction as load
- store_flag  in  1  ALU marks current instruction as store
- funct3  in  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- store_data  in  32  rs2 value
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- stall  out  1  core must hold current instruction
- wb_valid  out  1  wb_data valid for one cycle
- wb_data  out  32  extended load result
- bus_err  out  1  one-cycle error pulse
- misalign_err  out  1  one-cycle misalignment pulse

Behaviour:
- Reset: state IDLE. mem_req, mem_we, wb_valid, bus_err and misalign_err are 0. mem_addr, mem_be, mem_wdata and wb_data are 0. Timeout counter is 0. Reset asserted mid-transaction aborts immediately; mem_req drops asynchronously and no response is produced.
- States: IDLE, REQ, WAIT, RESP.
- stall is combinational: (IDLE & (load_flag|store_flag)) | REQ | WAIT. It is 0 in RESP.
- IDLE, exactly one flag set:
  - Latch address, funct3 and store data.
  - Compute mem_be/mem_wdata.
  - Go to REQ.
- IDLE error cases, go to RESP with no memory request and bus_err=1 in RESP:
  - Both flags set.
  - Unsupported funct3 (load 011/110/111; store anything above 010).
- REQ:
  - mem_req=1; mem_we=1 for a store.
  - Outputs are held stable until mem_gnt.
  - On gnt: store goes to RESP; load goes to WAIT.
- WAIT:
  - mem_rvalid is sampled only in this state, so the earliest return is the cycle after gnt.
  - On rvalid: capture and extract wb_data, go to RESP.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears on entering REQ.
  - Reaching MAX_WAIT forces RESP with bus_err=1, wb_valid=0 and mem_req=0.
- RESP: one cycle. wb_valid=1 only for a successful load. Go to IDLE. Flags seen during RESP belong to the same instruction and are ignored.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be=0011<<{addr[1],1'b0}, wdata = half replicated ×2.
  - SW: be=1111, wdata = store_data.
- Load extraction:
  - LB/LBU: byte addr[1:0], sign/zero-extended.
  - LH/LHU: half selected by addr[1], sign/zero-extended.
  - LW: full word.
- Latency with zero-wait memory:
  - Store: IDLE→REQ→RESP, 2 stall cycles.
  - Load: IDLE→REQ→WAIT→RESP, 3 stall cycles.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: the following cases get no memory request; the block goes straight to RESP with misalign_err=1 and wb_valid=0.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- Undefined:
  - Low bits are ignored: addr[0] for halves, addr[1:0] for words.
  - misalign_err is tied 0; the port always exists.

Decomposition:
- lsu_pkg holds:
  - State enum lsu_state_t.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - LOAD/STORE opcode constants, shared with the ALU.
- Sub-module lsu_align: purely combinational byte-lane logic (be/wdata generation and load extraction). lsu holds only the FSM, counter and registers.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt on first REQ cycle → mem_addr=0x100, be=1111, we=1, stall high 2 cycles, no wb_valid.
- LB addr=0x203, mem_rdata=0x80FF_1234, rvalid 3 cycles after gnt → wb_data=0xFFFFFF80, wb_valid 1 cycle; LBU same → 0x00000080.
- SH addr=0x06, store_data=0x0000ABCD → mem_addr=0x04, be=1100, wdata=0xABCDABCD.
- MAX_WAIT=4, gnt never asserted → bus_err pulse after 4 REQ cycles, mem_req drops, state returns IDLE.
- Load and store flags both high, or load funct3=011 → no mem_req, bus_err pulse, stall released after 1 cycle.
- With LSU_MISALIGN_CHK_EN: LW addr=0x102 → misalign_err pulse, no mem_req. Without it: mem_addr=0x100, normal load. Also assert rst during WAIT → mem_req/stall low immediately, next access proceeds normally.
